gin_mcast_bus: RTL and testbench

//  Buffered multicast bus for the GIN: one master stream fans out to NUMS_SLAVE PE ports.

---
 rtl/gin_pkg.sv | 13 +
 rtl/gin_mcast_slot.sv | 40 ++++
 rtl/gin_mcast_bus.sv | 124 ++++++++++++
 tb/tb_gin_mcast_bus.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gin_pkg.sv
// Shared definitions for the GIN multicast bus: widths, broadcast tag and FSM states.
package gin_pkg;

  localparam int DATA_BITS = 32;
  localparam int XID_BITS  = 5;
  localparam logic [XID_BITS-1:0] GIN_BCAST_TAG = '1;

  typedef enum logic {
    GIN_IDLE,
    GIN_DELIVER
  } gin_state_e;

endpackage

// File: rtl/gin_mcast_slot.sv
// One slave port of the multicast bus: scan-chain ID register, tag match,
// pending bit and valid gating.
module gin_mcast_slot #(
  parameter int ID_SIZE  = 5,
  parameter bit BCAST_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_id,
  input  logic [ID_SIZE-1:0] scan_in,
  input  logic [ID_SIZE-1:0] head_tag,
  input  logic               load,
  input  logic               slave_ready,
  output logic [ID_SIZE-1:0] id,
  output logic               match,
  output logic               slave_valid,
  output logic               pending_next
);

  logic pending;

  assign match        = (id == head_tag) || (BCAST_EN && (head_tag == {ID_SIZE{1'b1}}));
  assign slave_valid  = pending & ~set_id;
  assign pending_next = pending & ~(slave_valid & slave_ready);

  // The pending bit is captured from the match only at load time, so later
  // ID shifts never retarget a word already in delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      id      <= '0;
      pending <= 1'b0;
    end else begin
      if (set_id) begin
        id <= scan_in;
      end
      pending <= load ? match : pending_next;
    end
  end

endmodule

// File: rtl/gin_mcast_bus.sv
// Buffered multicast bus: master words pass through a small FIFO and are delivered
// to every slave whose ID matches the tag; the word retires once all have accepted.
module gin_mcast_bus
  import gin_pkg::*;
#(
  parameter int NUMS_SLAVE = 6,
  parameter int ID_SIZE    = gin_pkg::XID_BITS,
  parameter int DATA_BITS  = gin_pkg::DATA_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter bit BCAST_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_SIZE-1:0]    tag,
  input  logic                  master_valid,
  input  logic [DATA_BITS-1:0]  master_data,
  output logic                  master_ready,
  input  logic [NUMS_SLAVE-1:0] slave_ready,
  output logic [NUMS_SLAVE-1:0] slave_valid,
  output logic [DATA_BITS-1:0]  slave_data,
  input  logic                  set_id,
  input  logic [ID_SIZE-1:0]    ID_scan_in,
  output logic [ID_SIZE-1:0]    ID_scan_out,
  output logic [15:0]           drop_cnt,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_SIZE-1:0]    tag_mem  [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty, full, push, pop;

  gin_state_e            state, state_next;
  logic [ID_SIZE-1:0]    id_chain [NUMS_SLAVE];
  logic [NUMS_SLAVE-1:0] match, valid_raw, pending_next;
  logic [DATA_BITS-1:0]  data_q;
  logic [15:0]           drop_q;
  logic                  done, load;

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign master_ready = ~full & ~set_id & ~rst;
  assign push         = master_valid & master_ready;

  // A new head may be loaded when idle or when the current word retires this edge.
  assign done = (state == GIN_IDLE) || (pending_next == '0);
  assign load = ~empty & ~set_id & done;
  assign pop  = load;

  for (genvar i = 0; i < NUMS_SLAVE; i++) begin : g_slot
    logic [ID_SIZE-1:0] scan_src;
    if (i == 0) begin : g_first
      assign scan_src = ID_scan_in;
    end else begin : g_rest
      assign scan_src = id_chain[i-1];
    end
    gin_mcast_slot #(.ID_SIZE(ID_SIZE), .BCAST_EN(BCAST_EN)) u_slot (
      .clk          (clk),
      .rst          (rst),
      .set_id       (set_id),
      .scan_in      (scan_src),
      .head_tag     (tag_mem[rd_ptr]),
      .load         (load),
      .slave_ready  (slave_ready[i]),
      .id           (id_chain[i]),
      .match        (match[i]),
      .slave_valid  (valid_raw[i]),
      .pending_next (pending_next[i])
    );
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = (|match) ? GIN_DELIVER : GIN_IDLE;
    end else if (done) begin
      state_next = GIN_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= GIN_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      state <= state_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (load && (|match)) begin
        data_q <= data_mem[rd_ptr];
      end
      if (load && !(|match) && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr]  <= tag;
      data_mem[wr_ptr] <= master_data;
    end
  end

  assign slave_valid = rst ? '0 : valid_raw;
  assign slave_data  = rst ? '0 : data_q;
  assign ID_scan_out = rst ? '0 : id_chain[NUMS_SLAVE-1];
  assign drop_cnt    = drop_q;
  assign busy        = ~rst & (~empty | (state == GIN_DELIVER));

endmodule

// File: tb/tb_gin_mcast_bus.sv
// Self-checking bench for gin_mcast_bus: directed scenarios plus a random phase,
// all compared every cycle against a transaction-level model of the bus.
module tb_gin_mcast_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  tag = '0;
  logic        master_valid = 1'b0;
  logic [31:0] master_data = '0;
  logic        master_ready;
  logic [5:0]  slave_ready = '0;
  logic [5:0]  slave_valid;
  logic [31:0] slave_data;
  logic        set_id = 1'b0;
  logic [4:0]  ID_scan_in = '0;
  logic [4:0]  ID_scan_out;
  logic [15:0] drop_cnt;
  logic        busy;

  gin_mcast_bus dut (
    .clk          (clk),
    .rst          (rst),
    .tag          (tag),
    .master_valid (master_valid),
    .master_data  (master_data),
    .master_ready (master_ready),
    .slave_ready  (slave_ready),
    .slave_valid  (slave_valid),
    .slave_data   (slave_data),
    .set_id       (set_id),
    .ID_scan_in   (ID_scan_in),
    .ID_scan_out  (ID_scan_out),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
  } word_t;

  // Model: ID list, FIFO of words, the word in delivery with its outstanding slave set.
  logic [4:0]  m_ids [6];
  word_t       m_q [$];
  bit          m_active;
  logic [5:0]  m_pend;
  logic [31:0] m_data;
  int          m_drops;

  int n_cmp = 0;
  int n_fail = 0;

  logic [5:0]  s_valid;
  logic [31:0] s_data;
  logic        s_mready, s_busy;
  logic [4:0]  s_scan;
  logic [15:0] s_drop;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] match_of(input logic [4:0] t);
    logic [5:0] m = '0;
    for (int i = 0; i < 6; i++) m[i] = (m_ids[i] == t) || (t == 5'h1F);
    return m;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 6; i++) m_ids[i] = '0;
    m_q.delete();
    m_active = 0;
    m_pend = '0;
    m_data = '0;
    m_drops = 0;
  endtask

  task automatic modelStep();
    bit push_ok;
    logic [5:0] acc, newp, mm;
    word_t w;
    if (rst) begin
      modelReset();
      return;
    end
    push_ok = master_valid && (m_q.size() < 4) && !set_id;
    if (set_id) begin
      for (int i = 5; i > 0; i--) m_ids[i] = m_ids[i-1];
      m_ids[0] = ID_scan_in;
    end else begin
      acc  = (m_active ? m_pend : 6'h00) & slave_ready;
      newp = m_pend & ~acc;
      if (m_active && newp != 0) begin
        m_pend = newp;
      end else begin
        m_active = 0;
        m_pend = '0;
        if (m_q.size() > 0) begin
          w = m_q.pop_front();
          mm = match_of(w.tag);
          if (mm != 0) begin
            m_active = 1;
            m_pend = mm;
            m_data = w.data;
          end else if (m_drops < 65535) begin
            m_drops++;
          end
        end
      end
    end
    if (push_ok) m_q.push_back('{tag, master_data});
  endtask

  task automatic checkOutput();
    s_valid = slave_valid; s_data = slave_data; s_mready = master_ready;
    s_busy = busy; s_scan = ID_scan_out; s_drop = drop_cnt;
    if (rst) begin
      cmp("rst_valid", 32'(s_valid), 0);
      cmp("rst_data", s_data, 0);
      cmp("rst_scan", 32'(s_scan), 0);
      cmp("rst_mready", 32'(s_mready), 0);
      cmp("rst_busy", 32'(s_busy), 0);
    end else begin
      cmp("slave_valid", 32'(s_valid), 32'((m_active && !set_id) ? m_pend : 6'h00));
      cmp("slave_data", s_data, m_data);
      cmp("master_ready", 32'(s_mready), 32'((m_q.size() < 4) && !set_id));
      cmp("busy", 32'(s_busy), 32'((m_q.size() > 0) || m_active));
      cmp("ID_scan_out", 32'(s_scan), 32'(m_ids[5]));
      cmp("drop_cnt", 32'(s_drop), 32'(m_drops));
    end
  endtask

  task automatic applyStimulus(input bit r, input bit sid, input logic [4:0] sin,
                               input bit mv, input logic [4:0] tg, input logic [31:0] d,
                               input logic [5:0] rdy);
    @(negedge clk);
    rst = r; set_id = sid; ID_scan_in = sin;
    master_valid = mv; tag = tg; master_data = d; slave_ready = rdy;
    #2;
    checkOutput();
    @(posedge clk);
    modelStep();
  endtask

  task automatic loadIds();
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 5'(5 - k), 0, 0, 0, 6'h00);
  endtask

  initial begin
    modelReset();

    // Reset and ID load
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    loadIds();
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    cmp("lit_scan_out", 32'(s_scan), 5);
    cmp("lit_model_id0", 32'(m_ids[0]), 0);
    cmp("lit_model_id3", 32'(m_ids[3]), 3);

    // Unicast to slave 3
    applyStimulus(0, 0, 0, 1, 5'd3, 32'hA5A5, 6'h3F);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    cmp("lit_uni_valid", 32'(s_valid), 32'h08);
    cmp("lit_uni_data", s_data, 32'hA5A5);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    cmp("lit_uni_valid_off", 32'(s_valid), 0);

    // Broadcast with staggered readys
    applyStimulus(0, 0, 0, 1, 5'h1F, 32'hB0B0_0001, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h00);
    for (int k = 0; k < 8; k++) begin
      logic [6:0] r7;
      r7 = (7'd1 << (k + 1)) - 7'd1;
      applyStimulus(0, 0, 0, 0, 0, 0, (k >= 5) ? 6'h3F : r7[5:0]);
      if (k == 0) cmp("lit_bc_first", 32'(s_valid), 32'h3F);
      if (k == 5) cmp("lit_bc_last", 32'(s_valid), 32'h20);
      if (k == 6) cmp("lit_bc_done", 32'(s_busy), 0);
    end

    // Unmatched tag is dropped, next word reaches slave 2
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h9999, 6'h3F);
    applyStimulus(0, 0, 0, 1, 5'd2, 32'h2222, 6'h3F);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    cmp("lit_drop_valid", 32'(s_valid), 32'h04);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    cmp("lit_drop_cnt", 32'(s_drop), 1);

    // Backpressure: 4 in FIFO plus 1 in delivery, then drain
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 0, 0, 1, 5'($urandom_range(0, 5)), $urandom, 6'h00);
      if (k == 5) cmp("lit_full_mready", 32'(s_mready), 0);
    end
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);

    // Freeze during delivery, then reset mid-stream
    applyStimulus(0, 0, 0, 1, 5'd4, 32'hF00D, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h00);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 5'(k), 1, 5'd1, 32'hDEAD, 6'h3F);
      cmp("lit_freeze_valid", 32'(s_valid), 0);
      cmp("lit_freeze_mready", 32'(s_mready), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h00);
    cmp("lit_resume_data", s_data, 32'hF00D);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 5'h1F, 32'(k), 6'h00);
    applyStimulus(1, 0, 0, 1, 5'h1F, 32'h5, 6'h3F);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h3F);
    cmp("lit_post_rst_busy", 32'(s_busy), 0);

    // Random traffic
    loadIds();
    for (int n = 0; n < 400; n++) begin
      int x;
      logic [4:0] tg;
      x = $urandom_range(0, 9);
      tg = (x < 7) ? 5'(x) : ((x == 7) ? 5'h1F : 5'($urandom));
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0,
                    5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0, tg,
                    $urandom, 6'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
